systolic_array_mac_ctrl: RTL and testbench

//  Drives the array side of the systolic_array_MAC_if for an N x N weight-stationary array.
//  - Preloads weights row by row.
//  - Sequences each MAC operation: start, count, MAC_shift.
//  - Pops input rows, injects zero drain beats and flags valid bottom-row accumulates.
//  - Sits between the tile scheduler (command) and the array plus its I/O skew buffers.

---
 rtl/systolic_array_mac_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_systolic_array_mac_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_mac_ctrl.sv
// Array-side sequencer for an N x N weight-stationary systolic array: weight preload, MAC beat timing, drain beats.
// Optional macro SA_CTRL_PERF_EN adds a saturating stall_cycles counter output.
module systolic_array_mac_ctrl #(
    parameter int data_w  = 16,
    parameter int mul_len = 2,
    parameter int add_len = 3,
    parameter int N       = 4,
    parameter int ROW_W   = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 cmd_valid,
    input  logic [ROW_W-1:0]                     num_rows,
    output logic                                 cmd_ready,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    output logic [$clog2(N)-1:0]                 weight_row,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic                                 feed_zero,
    output logic                                 mac_start,
    output logic [$clog2(mul_len+add_len)-1:0]   mac_count,
    output logic                                 mac_shift,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 done
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]                          stall_cycles
`endif
);

    localparam int MAC_LEN = mul_len + add_len;
    localparam int CNT_W   = $clog2(MAC_LEN);
    localparam int WR_W    = $clog2(N);
    localparam int BEAT_W  = ROW_W + 1;

    // Counter widths collapse to zero below these sizes.
    if (N < 2 || MAC_LEN < 2 || data_w < 1) begin : g_bad_params
        $error("systolic_array_mac_ctrl: N and MAC_LEN must be >= 2, data_w >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        BEAT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   rows_reg, rows_next;
    logic [WR_W-1:0]    wrow_reg, wrow_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;
    logic [CNT_W-1:0]   cyc_reg, cyc_next;

    logic [BEAT_W-1:0]  beats_total;
    logic               data_beat;
    logic               last_beat;
    logic               cyc_last;

    // Beat counter is one bit wider than num_rows so R + N - 1 cannot wrap.
    assign beats_total = BEAT_W'(rows_reg) + BEAT_W'(N - 1);
    assign data_beat   = beat_reg < BEAT_W'(rows_reg);
    assign last_beat   = beat_reg == (beats_total - BEAT_W'(1));
    assign cyc_last    = cyc_reg == CNT_W'(MAC_LEN - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            rows_reg  <= '0;
            wrow_reg  <= '0;
            beat_reg  <= '0;
            cyc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rows_reg  <= rows_next;
            wrow_reg  <= wrow_next;
            beat_reg  <= beat_next;
            cyc_reg   <= cyc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rows_next  = rows_reg;
        wrow_next  = wrow_reg;
        beat_next  = beat_reg;
        cyc_next   = cyc_reg;
        cmd_ready  = 1'b0;
        w_ready    = 1'b0;
        weight_row = '0;
        in_ready   = 1'b0;
        feed_zero  = 1'b0;
        mac_start  = 1'b0;
        mac_count  = '0;
        mac_shift  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rows_next  = num_rows;
                    wrow_next  = '0;
                    beat_next  = '0;
                    cyc_next   = '0;
                    state_next = (num_rows == '0) ? DONE : LOAD_W;
                end
            end

            LOAD_W: begin
                busy       = 1'b1;
                weight_row = wrow_reg;
                w_ready    = w_valid;
                if (w_valid) begin
                    if (wrow_reg == WR_W'(N - 1)) begin
                        state_next = BEAT;
                        beat_next  = '0;
                        cyc_next   = '0;
                    end else begin
                        wrow_next = wrow_reg + 1'b1;
                    end
                end
            end

            BEAT: begin
                busy      = 1'b1;
                mac_count = cyc_reg;
                feed_zero = !data_beat;
                // A data beat cannot start until its input row is present.
                if (!(cyc_reg == '0 && data_beat && !in_valid)) begin
                    if (cyc_reg == '0) begin
                        mac_start = 1'b1;
                        in_ready  = data_beat;
                    end
                    if (cyc_last) begin
                        mac_shift = 1'b1;
                        out_valid = beat_reg >= BEAT_W'(N - 1);
                        cyc_next  = '0;
                        if (last_beat) begin
                            state_next = DONE;
                        end else begin
                            beat_next = beat_reg + 1'b1;
                        end
                    end else begin
                        cyc_next = cyc_reg + 1'b1;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] stall_reg;
    logic        stall_now;

    assign stall_now    = (state_reg == BEAT) && (cyc_reg == '0) && data_beat && !in_valid;
    assign stall_cycles = stall_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_reg <= '0;
        end else if (state_reg == IDLE && cmd_valid) begin
            stall_reg <= '0;
        end else if (stall_now && stall_reg != 32'hFFFF_FFFF) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_array_mac_ctrl.sv
// Self-checking bench: a procedural per-tile reference (rows, beats, cycles as nested loops)
// predicts every output each cycle under randomized handshake stalls.
module tb_systolic_array_mac_ctrl;

    localparam int N       = 4;
    localparam int MAC_LEN = 5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic [7:0]  num_rows;
    logic        cmd_ready;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  weight_row;
    logic        in_valid;
    logic        in_ready;
    logic        feed_zero;
    logic        mac_start;
    logic [2:0]  mac_count;
    logic        mac_shift;
    logic        out_valid;
    logic        busy;
    logic        done;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    systolic_array_mac_ctrl #(
        .data_w(16), .mul_len(2), .add_len(3), .N(N), .ROW_W(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .num_rows(num_rows), .cmd_ready(cmd_ready),
        .w_valid(w_valid), .w_ready(w_ready), .weight_row(weight_row),
        .in_valid(in_valid), .in_ready(in_ready), .feed_zero(feed_zero),
        .mac_start(mac_start), .mac_count(mac_count), .mac_shift(mac_shift),
        .out_valid(out_valid), .busy(busy), .done(done)
`ifdef SA_CTRL_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    logic [13:0] out_vec;
    assign out_vec = {cmd_ready, w_ready, weight_row, in_ready, feed_zero, mac_start,
                      mac_count, mac_shift, out_valid, busy, done};

    int n_checks = 0;
    int n_fail   = 0;
    int obs_ov, obs_ir, obs_ms, obs_sh;
    int w_gap  [N];
    int in_gap [64];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] ev(bit cr, bit wr, int wrow, bit ir, bit fz, bit ms,
                                       int mc, bit msh, bit ov, bit bsy, bit dn);
        return {cr, wr, 2'(wrow), ir, fz, ms, 3'(mc), msh, ov, bsy, dn};
    endfunction

    // Inputs are already driven at this negedge; compare mid-cycle, then move to next negedge.
    task automatic step(input string tag, input logic [13:0] exp);
        #1;
        check_eq(tag, 32'(out_vec), 32'(exp));
        if (out_valid) obs_ov++;
        if (in_ready)  obs_ir++;
        if (mac_start) obs_ms++;
        if (mac_shift) obs_sh++;
        @(negedge CLK);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_tile(input int r, input bit hold_cmd, input int abort_b, input int abort_c);
        int b_total;
        int stalls;
        bit fz, ms, sh, ov;
        obs_ov = 0; obs_ir = 0; obs_ms = 0; obs_sh = 0;
        stalls = 0;
        cmd_valid = 1'b1;
        num_rows  = 8'(r);
        w_valid   = rbit();
        in_valid  = rbit();
        step("accept", ev(1,0,0,0,0,0,0,0,0,0,0));
        if (!hold_cmd) cmd_valid = 1'b0;
        num_rows = 8'($urandom_range(0, 255));

        if (r > 0) begin
            for (int rr = 0; rr < N; rr++) begin
                for (int g = 0; g < w_gap[rr]; g++) begin
                    w_valid  = 1'b0;
                    in_valid = rbit();
                    step("load_wait", ev(0,0,rr,0,0,0,0,0,0,1,0));
                end
                w_valid  = 1'b1;
                in_valid = rbit();
                step("load_row", ev(0,1,rr,0,0,0,0,0,0,1,0));
            end
            b_total = r + N - 1;
            for (int b = 0; b < b_total; b++) begin
                for (int c = 0; c < MAC_LEN; c++) begin
                    w_valid = rbit();
                    if (c == 0 && b < r) begin
                        for (int g = 0; g < in_gap[b]; g++) begin
                            in_valid = 1'b0;
                            stalls++;
                            step("stall", ev(0,0,0,0,0,0,0,0,0,1,0));
                        end
                        in_valid = 1'b1;
                    end else begin
                        in_valid = rbit();
                    end
                    fz = (b >= r);
                    ms = (c == 0);
                    sh = (c == MAC_LEN - 1);
                    ov = sh && (b >= N - 1);
                    if (b == abort_b && c == abort_c) begin
                        RST = 1'b1;
                        cmd_valid = 1'b0;
                        step("abort_cycle", ev(0,0,0,ms && !fz,fz,ms,c,sh,ov,1,0));
                        RST = 1'b0;
                        step("after_reset", ev(1,0,0,0,0,0,0,0,0,0,0));
`ifdef SA_CTRL_PERF_EN
                        check_eq("stall_after_reset", stall_cycles, 32'd0);
`endif
                        $display("tile R=%0d aborted at beat %0d cycle %0d", r, b, c);
                        return;
                    end
                    step("beat", ev(0,0,0,ms && !fz,fz,ms,c,sh,ov,1,0));
                end
            end
        end
        w_valid  = rbit();
        in_valid = rbit();
        step("done", ev(0,0,0,0,0,0,0,0,0,0,1));
        check_eq("out_valid_count", 32'(obs_ov), 32'(r));
        check_eq("in_ready_count", 32'(obs_ir), 32'(r));
        check_eq("mac_start_count", 32'(obs_ms), (r == 0) ? 32'd0 : 32'(r + N - 1));
        check_eq("mac_shift_count", 32'(obs_sh), (r == 0) ? 32'd0 : 32'(r + N - 1));
`ifdef SA_CTRL_PERF_EN
        check_eq("stall_cycles", stall_cycles, 32'(stalls));
`endif
        $display("tile R=%0d stalls=%0d out_valid=%0d in_ready=%0d", r, stalls, obs_ov, obs_ir);
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < N; i++) w_gap[i] = 0;
        for (int i = 0; i < 64; i++) in_gap[i] = 0;
    endtask

    task automatic random_gaps();
        for (int i = 0; i < N; i++) w_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i < 64; i++) in_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    endtask

    task automatic idle_cycle();
        cmd_valid = 1'b0;
        w_valid   = rbit();
        in_valid  = rbit();
        step("idle", ev(1,0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        RST = 1'b1;
        cmd_valid = 1'b1;
        num_rows  = 8'd3;
        w_valid   = 1'b1;
        in_valid  = 1'b1;
        repeat (3) @(negedge CLK);
        step("reset", ev(1,0,0,0,0,0,0,0,0,0,0));
        RST = 1'b0;
        idle_cycle();

        clear_gaps();
        run_tile(2, 1'b0, -1, 0);
        idle_cycle();
        run_tile(0, 1'b0, -1, 0);
        idle_cycle();
        clear_gaps();
        in_gap[1] = 7;
        run_tile(3, 1'b0, -1, 0);
        idle_cycle();
        clear_gaps();
        w_gap[1] = 1; w_gap[2] = 1; w_gap[3] = 1;
        run_tile(1, 1'b0, -1, 0);
        idle_cycle();
        clear_gaps();
        run_tile(3, 1'b0, 2, 3);
        run_tile(1, 1'b0, -1, 0);
        idle_cycle();
        run_tile(2, 1'b1, -1, 0);
        run_tile(1, 1'b0, -1, 0);

        for (int t = 0; t < 25; t++) begin
            random_gaps();
            if ($urandom_range(0, 1) == 1) idle_cycle();
            run_tile(int'($urandom_range(0, 7)), rbit(), -1, 0);
        end
        cmd_valid = 1'b0;
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
